// File: rtl/dim_linked_dot_engine.sv
// Purpose : PE-lane streaming dot product over BDIM elements, plus one bias, one result per block, tlast per SDIM blocks.
// Latency : BEATS join transfers, one bias cycle, then the result is valid the cycle after bias acceptance (BEATS+2 minimum period).
// Backpress: input/weights are joined (neither consumed alone); no input or bias accepted while a result waits for m_axis_output_tready.
//
// Ports:
//   ap_clk / ap_rst            clock, synchronous active-high reset
//   s_axis_input_*             PE input lanes (lane 0 in LSBs), valid/ready
//   s_axis_weights_*           PE weight lanes, valid/ready (joined with input)
//   bias_values_*              one signed bias per block, valid/ready
//   m_axis_output_*            result, valid/ready, tlast on the last block of a frame
//
// Optional feature: define DIM_LINKED_DOT_SAT_EN to saturate (instead of wrap)
// results that do not fit a narrower m_axis_output_WIDTH.
module dim_linked_dot_engine #(
    parameter int s_axis_input_BDIM     = 64,
    parameter int s_axis_input_SDIM     = 16,
    parameter int PE                    = 8,
    parameter int s_axis_input_WIDTH    = 8,
    parameter int s_axis_input_SIGNED   = 1,
    parameter int s_axis_weights_WIDTH  = 8,
    parameter int s_axis_weights_SIGNED = 1,
    parameter int bias_values_WIDTH     = 32,
    parameter int m_axis_output_WIDTH   = 32
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst,
    input  logic [PE*s_axis_input_WIDTH-1:0]     s_axis_input_tdata,
    input  logic                                 s_axis_input_tvalid,
    output logic                                 s_axis_input_tready,
    input  logic [PE*s_axis_weights_WIDTH-1:0]   s_axis_weights_tdata,
    input  logic                                 s_axis_weights_tvalid,
    output logic                                 s_axis_weights_tready,
    input  logic [bias_values_WIDTH-1:0]         bias_values_tdata,
    input  logic                                 bias_values_tvalid,
    output logic                                 bias_values_tready,
    output logic [m_axis_output_WIDTH-1:0]       m_axis_output_tdata,
    output logic                                 m_axis_output_tvalid,
    input  logic                                 m_axis_output_tready,
    output logic                                 m_axis_output_tlast
);

    localparam int IW    = s_axis_input_WIDTH;
    localparam int WW    = s_axis_weights_WIDTH;
    localparam int OW    = m_axis_output_WIDTH;
    localparam int BEATS = s_axis_input_BDIM / PE;
    localparam int ACC_W = IW + WW + $clog2(s_axis_input_BDIM) + 1;
    localparam int RES_W = ACC_W + 1;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SC_W  = (s_axis_input_SDIM > 1) ? $clog2(s_axis_input_SDIM) : 1;

    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);
    localparam logic [SC_W-1:0] LAST_BLK  = SC_W'(s_axis_input_SDIM - 1);

    typedef enum logic [1:0] {
        ST_ACC,
        ST_BIAS,
        ST_OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [BC_W-1:0]         beat_cnt;
    logic [SC_W-1:0]         blk_cnt;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        beat_sum;
    logic signed [RES_W-1:0] res_nxt;
    logic [OW-1:0]           out_nxt;
    logic [OW-1:0]           out_dat;
    logic                    out_last;

    logic join_rdy;
    logic bias_rdy;
    logic out_vld;
    logic join_xfer;
    logic bias_xfer;
    logic out_xfer;

    // Lane extension to the accumulator width; the sign bit is replicated only
    // for signed streams, so unsigned lanes are zero-extended.
    function automatic logic [ACC_W-1:0] ext_in(input logic [IW-1:0] v);
        return {{(ACC_W-IW){v[IW-1] & (s_axis_input_SIGNED != 0)}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] ext_w(input logic [WW-1:0] v);
        return {{(ACC_W-WW){v[WW-1] & (s_axis_weights_SIGNED != 0)}}, v};
    endfunction

    // Low ACC_W bits of a two's-complement product do not depend on operand
    // signedness once both operands are extended, so a plain multiply suffices.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < PE; i++) begin
            beat_sum = beat_sum
                     + ext_in(s_axis_input_tdata[i*IW +: IW]) * ext_w(s_axis_weights_tdata[i*WW +: WW]);
        end
    end

    // Bias is always signed; the cast sign-extends or drops high bits to RES_W.
    assign res_nxt = RES_W'(signed'(acc)) + RES_W'(signed'(bias_values_tdata));

    generate
        if (OW >= RES_W) begin : g_wide
            assign out_nxt = OW'(res_nxt);
        end else begin : g_narrow
`ifdef DIM_LINKED_DOT_SAT_EN
            logic fits;
            // Fits when every bit above the output sign bit equals the result sign.
            assign fits    = (res_nxt[RES_W-1:OW-1] == {(RES_W-OW+1){res_nxt[RES_W-1]}});
            assign out_nxt = fits            ? res_nxt[OW-1:0]
                           : res_nxt[RES_W-1] ? {1'b1, {(OW-1){1'b0}}}
                           :                    {1'b0, {(OW-1){1'b1}}};
`else
            logic unused_res_hi;
            assign unused_res_hi = ^res_nxt[RES_W-1:OW];
            assign out_nxt       = res_nxt[OW-1:0];
`endif
        end
    endgenerate

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        join_rdy  = 1'b0;
        bias_rdy  = 1'b0;
        out_vld   = 1'b0;
        case (state)
            ST_ACC: begin
                join_rdy = s_axis_input_tvalid & s_axis_weights_tvalid;
                if (join_rdy && (beat_cnt == LAST_BEAT)) begin
                    state_nxt = ST_BIAS;
                end
            end
            ST_BIAS: begin
                bias_rdy = 1'b1;
                if (bias_values_tvalid) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                out_vld = 1'b1;
                if (m_axis_output_tready) begin
                    state_nxt = ST_ACC;
                end
            end
            default: state_nxt = ST_ACC;
        endcase
        // Handshake outputs stay low while reset is asserted, whatever the state.
        if (ap_rst) begin
            join_rdy = 1'b0;
            bias_rdy = 1'b0;
            out_vld  = 1'b0;
        end
    end

    assign join_xfer = join_rdy;
    assign bias_xfer = bias_rdy & bias_values_tvalid;
    assign out_xfer  = out_vld & m_axis_output_tready;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            beat_cnt <= '0;
            blk_cnt  <= '0;
            acc      <= '0;
            out_dat  <= '0;
            out_last <= 1'b0;
        end else begin
            if (join_xfer) begin
                // First beat of a block overwrites acc, so no clear cycle is needed.
                acc      <= (beat_cnt == '0) ? beat_sum : acc + beat_sum;
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
            if (bias_xfer) begin
                out_dat  <= out_nxt;
                out_last <= (blk_cnt == LAST_BLK);
            end
            if (out_xfer) begin
                blk_cnt <= (blk_cnt == LAST_BLK) ? '0 : blk_cnt + 1'b1;
            end
        end
    end

    assign s_axis_input_tready   = join_rdy;
    assign s_axis_weights_tready = join_rdy;
    assign bias_values_tready    = bias_rdy;
    assign m_axis_output_tvalid  = out_vld;
    assign m_axis_output_tdata   = out_dat;
    assign m_axis_output_tlast   = out_last;

endmodule

// File: tb/tb_dim_linked_dot_engine.sv
// Bench for dim_linked_dot_engine: three instances share one stimulus stream
// (signed/32-bit out, unsigned/32-bit out, signed/16-bit out) and are checked
// against a per-block arithmetic model (BDIM=4, PE=2, SDIM=3).
module tb_dim_linked_dot_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_dat;
    logic        in_vld;
    logic [15:0] w_dat;
    logic        w_vld;
    logic [7:0]  b_dat;
    logic        b_vld;
    logic        o_rdy;

    logic        in_rdy_s, w_rdy_s, b_rdy_s, o_vld_s, o_last_s;
    logic [31:0] o_dat_s;
    logic        in_rdy_u, w_rdy_u, b_rdy_u, o_vld_u, o_last_u;
    logic [31:0] o_dat_u;
    logic        in_rdy_n, w_rdy_n, b_rdy_n, o_vld_n, o_last_n;
    logic [15:0] o_dat_n;

    int total = 0;
    int bad   = 0;

    // Reference model state: per-block sums and block index within the frame.
    longint sum_s;
    longint sum_u;
    int     blk;
    longint exp_s, exp_u, exp_n;
    bit     exp_last;
    longint seen_s, seen_n;

    always #5 clk = ~clk;

    dim_linked_dot_engine #(
        .s_axis_input_BDIM(4), .s_axis_input_SDIM(3), .PE(2),
        .s_axis_input_WIDTH(8), .s_axis_input_SIGNED(1),
        .s_axis_weights_WIDTH(8), .s_axis_weights_SIGNED(1),
        .bias_values_WIDTH(8), .m_axis_output_WIDTH(32)
    ) u_s (
        .ap_clk(clk), .ap_rst(rst),
        .s_axis_input_tdata(in_dat), .s_axis_input_tvalid(in_vld), .s_axis_input_tready(in_rdy_s),
        .s_axis_weights_tdata(w_dat), .s_axis_weights_tvalid(w_vld), .s_axis_weights_tready(w_rdy_s),
        .bias_values_tdata(b_dat), .bias_values_tvalid(b_vld), .bias_values_tready(b_rdy_s),
        .m_axis_output_tdata(o_dat_s), .m_axis_output_tvalid(o_vld_s),
        .m_axis_output_tready(o_rdy), .m_axis_output_tlast(o_last_s)
    );

    dim_linked_dot_engine #(
        .s_axis_input_BDIM(4), .s_axis_input_SDIM(3), .PE(2),
        .s_axis_input_WIDTH(8), .s_axis_input_SIGNED(0),
        .s_axis_weights_WIDTH(8), .s_axis_weights_SIGNED(0),
        .bias_values_WIDTH(8), .m_axis_output_WIDTH(32)
    ) u_u (
        .ap_clk(clk), .ap_rst(rst),
        .s_axis_input_tdata(in_dat), .s_axis_input_tvalid(in_vld), .s_axis_input_tready(in_rdy_u),
        .s_axis_weights_tdata(w_dat), .s_axis_weights_tvalid(w_vld), .s_axis_weights_tready(w_rdy_u),
        .bias_values_tdata(b_dat), .bias_values_tvalid(b_vld), .bias_values_tready(b_rdy_u),
        .m_axis_output_tdata(o_dat_u), .m_axis_output_tvalid(o_vld_u),
        .m_axis_output_tready(o_rdy), .m_axis_output_tlast(o_last_u)
    );

    dim_linked_dot_engine #(
        .s_axis_input_BDIM(4), .s_axis_input_SDIM(3), .PE(2),
        .s_axis_input_WIDTH(8), .s_axis_input_SIGNED(1),
        .s_axis_weights_WIDTH(8), .s_axis_weights_SIGNED(1),
        .bias_values_WIDTH(8), .m_axis_output_WIDTH(16)
    ) u_n (
        .ap_clk(clk), .ap_rst(rst),
        .s_axis_input_tdata(in_dat), .s_axis_input_tvalid(in_vld), .s_axis_input_tready(in_rdy_n),
        .s_axis_weights_tdata(w_dat), .s_axis_weights_tvalid(w_vld), .s_axis_weights_tready(w_rdy_n),
        .bias_values_tdata(b_dat), .bias_values_tvalid(b_vld), .bias_values_tready(b_rdy_n),
        .m_axis_output_tdata(o_dat_n), .m_axis_output_tvalid(o_vld_n),
        .m_axis_output_tready(o_rdy), .m_axis_output_tlast(o_last_n)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint lane(input logic [7:0] x, input bit sgn);
        return sgn ? longint'($signed(x)) : longint'(x);
    endfunction

    // Expected 16-bit output of the narrow instance for a full-precision result.
    function automatic longint narrow16(input longint r);
        logic [15:0] lo;
`ifdef DIM_LINKED_DOT_SAT_EN
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return r;
`else
        lo = r[15:0];
        return longint'($signed(lo));
`endif
    endfunction

    // Entered and left #1 after a rising edge.
    task automatic reset_pulse();
        rst = 1'b1; in_vld = 1'b1; w_vld = 1'b1; b_vld = 1'b1; o_rdy = 1'b1;
        @(negedge clk);
        check("rst_in_rdy",   {in_rdy_s, in_rdy_u, in_rdy_n}, 0);
        check("rst_w_rdy",    {w_rdy_s, w_rdy_u, w_rdy_n}, 0);
        check("rst_bias_rdy", {b_rdy_s, b_rdy_u, b_rdy_n}, 0);
        check("rst_out_vld",  {o_vld_s, o_vld_u, o_vld_n}, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_vld = 1'b0; w_vld = 1'b0; b_vld = 1'b0; o_rdy = 1'b0;
        @(negedge clk);
        check("rst_out_dat",  $signed(o_dat_s), 0);
        check("rst_out_last", {o_last_s, o_last_u, o_last_n}, 0);
        sum_s = 0; sum_u = 0; blk = 0;
        @(posedge clk); #1;
    endtask

    task automatic do_beat(input logic [15:0] a, input logic [15:0] b, input int hold_w);
        int n;
        in_dat = a; w_dat = b; in_vld = 1'b1; w_vld = (hold_w == 0);
        for (int k = 0; k < hold_w; k++) begin
            @(negedge clk);
            check("join_hold_in_rdy", in_rdy_s, 0);
            check("join_hold_w_rdy", w_rdy_s, 0);
            @(posedge clk); #1;
        end
        w_vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_rdy_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("beat_accept", {in_rdy_s, w_rdy_s}, 2'b11);
        check("beat_rdy_other", {in_rdy_u, w_rdy_u, in_rdy_n, w_rdy_n}, 4'hF);
        sum_s += lane(a[7:0], 1) * lane(b[7:0], 1) + lane(a[15:8], 1) * lane(b[15:8], 1);
        sum_u += lane(a[7:0], 0) * lane(b[7:0], 0) + lane(a[15:8], 0) * lane(b[15:8], 0);
        @(posedge clk); #1;
        in_vld = 1'b0; w_vld = 1'b0;
    endtask

    // Bias handshake, result checks, optional output stall; abort resets while in OUT.
    task automatic block_end(input logic [7:0] bias, input int stall, input bit abort);
        int n;
        longint bx;
        b_dat = bias; b_vld = 1'b1;
        in_vld = 1'b1; w_vld = 1'b1;
        in_dat = 16'($urandom); w_dat = 16'($urandom);
        n = 0;
        @(negedge clk);
        while (!b_rdy_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bias_rdy", {b_rdy_s, b_rdy_u, b_rdy_n}, 3'b111);
        check("bias_no_join", in_rdy_s, 0);
        check("bias_pre_vld", o_vld_s, 0);
        @(posedge clk); #1;
        b_dat = 8'($urandom);
        bx       = longint'($signed(bias));
        exp_s    = sum_s + bx;
        exp_u    = sum_u + bx;
        exp_n    = narrow16(exp_s);
        exp_last = (blk == 2);
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            check("out_vld", {o_vld_s, o_vld_u, o_vld_n}, 3'b111);
            check("out_dat_s", $signed(o_dat_s), exp_s);
            check("out_dat_u", $signed(o_dat_u), exp_u);
            check("out_dat_n", $signed(o_dat_n), exp_n);
            check("out_last", {o_last_s, o_last_u, o_last_n}, {3{exp_last}});
            check("out_no_join", in_rdy_s, 0);
            check("out_no_bias", b_rdy_s, 0);
        end
        seen_s = $signed(o_dat_s);
        seen_n = $signed(o_dat_n);
        if (abort) begin
            @(posedge clk); #1;
            reset_pulse();
        end else begin
            o_rdy = 1'b1;
            @(posedge clk); #1;
            o_rdy = 1'b0; in_vld = 1'b0; w_vld = 1'b0; b_vld = 1'b0;
            @(negedge clk);
            check("out_dropped", o_vld_s, 0);
            sum_s = 0; sum_u = 0; blk = (blk + 1) % 3;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_block(input logic [15:0] a0, input logic [15:0] b0,
                             input logic [15:0] a1, input logic [15:0] b1,
                             input logic [7:0] bias, input int hold, input int stall);
        do_beat(a0, b0, hold);
        do_beat(a1, b1, 0);
        block_end(bias, stall, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; w_vld = 1'b0; b_vld = 1'b0; o_rdy = 1'b0;
        in_dat = '0; w_dat = '0; b_dat = '0;
        sum_s = 0; sum_u = 0; blk = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();

        // Basic block: in={1,2},{3,4}, w={1,1},{2,2}, bias 10.
        run_block(16'h0201, 16'h0101, 16'h0403, 16'h0202, 8'd10, 0, 0);
        check("basic_value", seen_s, 27);

        // Frame wrap with zero sums, tlast on the third block of the frame.
        run_block(16'h0000, 16'h0505, 16'h0000, 16'h0707, 8'd5, 0, 0);
        run_block(16'h0000, 16'h0505, 16'h0000, 16'h0707, 8'd6, 0, 0);
        run_block(16'h0000, 16'h0505, 16'h0000, 16'h0707, 8'd7, 0, 0);

        // Join backpressure, then output stall.
        run_block(16'h0302, 16'h0405, 16'hFF01, 16'h0203, 8'd1, 3, 0);
        run_block(16'h0102, 16'h0304, 16'h0506, 16'h0708, 8'hFC, 0, 5);

        // Signed extremes: 4 * 16384 - 1.
        run_block(16'h8080, 16'h8080, 16'h8080, 16'h8080, 8'hFF, 0, 0);
        check("extreme_wide", seen_s, 65535);
`ifdef DIM_LINKED_DOT_SAT_EN
        check("extreme_narrow", seen_n, 32767);
`else
        check("extreme_narrow", seen_n, -1);
`endif

        // Reset after one beat, with the frame mid-way: restart at block 0.
        do_beat(16'h7F7F, 16'h7F7F, 0);
        reset_pulse();
        for (int i = 0; i < 3; i++) begin
            run_block(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 0, 0);
        end

        // Reset while a result is pending.
        run_block(16'h1111, 16'h2222, 16'h3333, 16'h4444, 8'd3, 0, 0);
        do_beat(16'h0909, 16'h0909, 0);
        do_beat(16'h0909, 16'h0909, 0);
        block_end(8'd2, 2, 1'b1);
        run_block(16'h0101, 16'h0101, 16'h0101, 16'h0101, 8'd0, 0, 0);
        check("post_abort_value", seen_s, 4);

        // Randomized blocks.
        for (int i = 0; i < 24; i++) begin
            run_block(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
